// File: rtl/sobel_frame_writer_pkg.sv
// Shared definitions for the Sobel frame writer: bus FSM states, CI opcodes, bus constants.
package sobel_frame_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEGIN,
    ST_DATA,
    ST_END
  } busState_t;

  localparam logic [1:0] OP_SET_BASE = 2'd0;
  localparam logic [1:0] OP_ARM      = 2'd1;
  localparam logic [1:0] OP_STATUS   = 2'd2;
  localparam logic [1:0] OP_FRAMES   = 2'd3;

  localparam logic [3:0] BYTE_ENABLE_ALL = 4'hF;

endpackage

// File: rtl/sobel_word_fifo.sv
// Synchronous 32-bit word FIFO; a push at full is accepted only alongside a pop.
module sobel_word_fifo #(
  parameter int unsigned depth = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              pushData,
  output logic [31:0]              popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem [depth];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sobel_frame_writer.sv
// Packs filtered pixels into words, buffers them and bursts each frame to memory over the shared bus.
module sobel_frame_writer
  import sobel_frame_writer_pkg::*;
#(
  parameter logic [7:0]  customId   = 8'd0,
  parameter int unsigned fifoDepth  = 32,
  parameter int unsigned burstWords = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  input  logic        pixelValid,
  input  logic [15:0] pixelData,
  input  logic        hsync,
  input  logic        vsync,
  output logic        requestBus,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        endTransactionOut,
  output logic [3:0]  byteEnablesOut,
  output logic        dataValidOut,
  output logic [7:0]  burstSizeOut,
  input  logic        busyIn,
  input  logic        busErrorIn
);
  localparam int unsigned       CW          = $clog2(fifoDepth) + 1;
  localparam logic [CW-1:0]     BURST_COUNT = CW'(burstWords);
  localparam logic [8:0]        BURST_LEN   = 9'(burstWords);

  busState_t   state, stateNext;
  logic [31:0] baseAddr, writeAddr, frameCount;
  logic        armed, frameActive, flush, errorFlag, overflowFlag;
  logic [15:0] packLow;
  logic        packHalf;
  logic [8:0]  burstLen, wordCnt, discardCnt;

  logic          fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic [31:0]   fifoHead, pushWord;

  logic       ciHit, disarm, statusRead, captureOn, armedVsync;
  logic       busy, startBurst, busError, frameDone;
  logic [1:0] ciOp;
  logic       unusedBits;

  assign unusedBits = ^{ciValueA[31:2], ciValueB[1]};

  assign ciOp       = ciValueA[1:0];
  assign ciHit      = ciStart && (ciN == customId);
  assign ciDone     = ciHit && reset;
  assign disarm     = ciHit && (ciOp == OP_ARM) && !ciValueB[0];
  assign statusRead = ciHit && (ciOp == OP_STATUS);
  assign armedVsync = vsync && armed;
  assign captureOn  = armed && frameActive && !disarm && !armedVsync;
  assign busy       = (state != ST_IDLE) || !fifoEmpty || frameActive;
  assign busError   = ((state == ST_BEGIN) || (state == ST_DATA)) && busErrorIn;
  // While disarmed, any leftover words are drained like an end-of-frame flush.
  assign startBurst = (discardCnt == '0) &&
                      ((fifoCount >= BURST_COUNT) || ((flush || !armed) && !fifoEmpty));
  assign frameDone  = flush && fifoEmpty && (state == ST_IDLE) && (discardCnt == '0);
  // Words left over from an errored burst are popped and thrown away.
  assign fifoPop    = ((state == ST_DATA) && !busyIn && !busErrorIn) || (discardCnt != '0);

  always_comb begin
    ciResult = '0;
    if (ciDone) begin
      case (ciOp)
        OP_STATUS: ciResult = {29'd0, errorFlag, overflowFlag, busy};
        OP_FRAMES: ciResult = frameCount;
        default:   ciResult = '0;
      endcase
    end
  end

  always_comb begin
    fifoPush = 1'b0;
    pushWord = '0;
    if (captureOn) begin
      if (pixelValid) begin
        if (packHalf) begin
          fifoPush = 1'b1;
          pushWord = {pixelData, packLow};
        end else if (hsync) begin
          fifoPush = 1'b1;
          pushWord = {16'd0, pixelData};
        end
      end else if (hsync && packHalf) begin
        fifoPush = 1'b1;
        pushWord = {16'd0, packLow};
      end
    end
  end

  sobel_word_fifo #(.depth(fifoDepth)) wordFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifoPush),
    .pop      (fifoPop),
    .pushData (pushWord),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (startBurst) stateNext = ST_REQ;
      ST_REQ:   if (busGrant) stateNext = ST_BEGIN;
      ST_BEGIN: stateNext = busErrorIn ? ST_END : ST_DATA;
      ST_DATA:  if (busErrorIn || (!busyIn && (wordCnt == burstLen - 9'd1))) stateNext = ST_END;
      ST_END:   stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    requestBus          = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = '0;
    endTransactionOut   = 1'b0;
    byteEnablesOut      = '0;
    dataValidOut        = 1'b0;
    burstSizeOut        = '0;
    case (state)
      ST_REQ: requestBus = 1'b1;
      ST_BEGIN: begin
        requestBus          = 1'b1;
        beginTransactionOut = 1'b1;
        addressDataOut      = writeAddr;
        burstSizeOut        = 8'(burstLen - 9'd1);
        byteEnablesOut      = BYTE_ENABLE_ALL;
      end
      ST_DATA: begin
        requestBus     = 1'b1;
        dataValidOut   = 1'b1;
        addressDataOut = fifoHead;
      end
      ST_END:  endTransactionOut = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      burstLen   <= '0;
      wordCnt    <= '0;
      discardCnt <= '0;
    end else begin
      if ((state == ST_IDLE) && startBurst) begin
        burstLen <= (fifoCount >= BURST_COUNT) ? BURST_LEN : 9'(fifoCount);
        wordCnt  <= '0;
      end else if ((state == ST_DATA) && !busyIn && !busErrorIn) begin
        wordCnt <= wordCnt + 9'd1;
      end
      if (busError)              discardCnt <= burstLen - wordCnt;
      else if (discardCnt != '0) discardCnt <= discardCnt - 9'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baseAddr     <= '0;
      writeAddr    <= '0;
      armed        <= 1'b0;
      frameActive  <= 1'b0;
      flush        <= 1'b0;
      frameCount   <= '0;
      errorFlag    <= 1'b0;
      overflowFlag <= 1'b0;
      packLow      <= '0;
      packHalf     <= 1'b0;
    end else begin
      if (ciHit && (ciOp == OP_SET_BASE)) baseAddr <= {ciValueB[31:2], 2'b00};
      if (ciHit && (ciOp == OP_ARM))      armed    <= ciValueB[0];

      if (armedVsync)            writeAddr <= baseAddr;
      else if (state == ST_END)  writeAddr <= writeAddr + {21'd0, burstLen, 2'b00};

      if (disarm)     frameActive <= 1'b0;
      else if (vsync) frameActive <= armed;

      if (vsync && frameActive) begin
        flush <= 1'b1;
      end else if (frameDone) begin
        flush      <= 1'b0;
        frameCount <= frameCount + 32'd1;
      end

      if (busError)        errorFlag <= 1'b1;
      else if (statusRead) errorFlag <= 1'b0;

      if (fifoPush && fifoFull && !fifoPop) overflowFlag <= 1'b1;
      else if (statusRead)                  overflowFlag <= 1'b0;

      if (armedVsync) begin
        packLow  <= '0;
        packHalf <= 1'b0;
      end else if (captureOn) begin
        if (pixelValid) begin
          if (!packHalf && !hsync) begin
            packLow  <= pixelData;
            packHalf <= 1'b1;
          end else begin
            packHalf <= 1'b0;
          end
        end else if (hsync) begin
          packHalf <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sobel_frame_writer.md
Name: sobel_frame_writer

Overview:
Downstream stage of the Sobel accelerator. It takes the 16-bit filtered pixel stream, packs pixel pairs into 32-bit words and buffers them in a word FIFO. It then writes each frame to a memory frame buffer as burst transactions on the shared bus. The CPU configures and monitors the block through the custom-instruction interface.

Parameters:
customId, 8'd0, custom-instruction id this block answers to
fifoDepth, 32, FIFO depth in 32-bit words (power of two, >= 2*burstWords)
burstWords, 16, maximum words per bus burst (1..256)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
ciStart  in  1  custom-instruction strobe
ciN  in  8  custom-instruction id
ciValueA  in  32  opcode in [1:0]
ciValueB  in  32  operand
ciResult  out  32  read data; 0 unless ciDone
ciDone  out  1  one-cycle completion pulse
pixelValid  in  1  pixelData is valid this cycle
pixelData  in  16  filtered pixel
hsync  in  1  line-end pulse
vsync  in  1  frame-boundary pulse
requestBus  out  1  bus request
busGrant  in  1  bus grant
beginTransactionOut  out  1  burst start
addressDataOut  out  32  address in begin cycle, data in data cycles, else 0
endTransactionOut  out  1  burst end
byteEnablesOut  out  4  4'hF in begin cycle, else 0
dataValidOut  out  1  data word valid
burstSizeOut  out  8  words-1 in begin cycle, else 0
busyIn  in  1  slave stall
busErrorIn  in  1  slave error

Behaviour:
- Reset (reset=0): all outputs 0, FSM IDLE, FIFO empty, base/write address 0, flags 0, frame count 0, disarmed. A reset mid-burst abandons the burst.
- CI: when ciStart && ciN==customId, ciDone=1 in the same cycle (combinational).
  - Op 0: base <= {ciValueB[31:2],2'b00}.
  - Op 1: armed <= ciValueB[0].
  - Op 2: returns {29'd0, error, overflow, busy} and clears error and overflow.
  - Op 3: returns frame count.
- Capture: an armed vsync pulse starts a frame.
  - Write address <= base, pack register cleared, frameActive=1.
  - The FIFO is not cleared; pending words drain first.
- Packing: the first pixelValid of a pair goes to bits [15:0], the second to [31:16], then the word is pushed.
- hsync with a half-filled pair pushes the word with [31:16]=0.
- Capture is ignored when not armed or not frameActive.
- Disarm takes effect at once for capture; an in-flight burst completes.
- FIFO push with count==fifoDepth and no pop that cycle: word dropped, overflow set (sticky).
- Simultaneous push and pop at full: push accepted.
- FSM states and transitions:
  - IDLE: go to REQ when count>=burstWords, or when flushing (vsync while frameActive, or disarm) with count>0. n = min(count, burstWords), latched.
  - REQ: requestBus=1 until busGrant, then BEGIN.
  - BEGIN (1 cycle): beginTransactionOut=1, addressDataOut=write address, burstSizeOut=n-1, byteEnablesOut=4'hF.
  - DATA: dataValidOut=1, addressDataOut=FIFO head. The word pops and the counter advances on cycles with busyIn=0. After n words go to END.
  - END (1 cycle): endTransactionOut=1, requestBus=0, write address += 4n (mod 2^32), then IDLE.
- requestBus stays high from REQ through DATA.
- busErrorIn in BEGIN or DATA: next state END, error set. Remaining burst words are popped and discarded; address still advances 4n.
- End of frame: vsync while frameActive sets flush. Frame count increments (wraps at 2^32) when flush is pending, FIFO is empty and FSM is IDLE; then flush clears. That vsync also restarts capture if armed.
- busy = FSM!=IDLE || FIFO non-empty || frameActive.

Decomposition:
- Shared package holds:
  - FSM state encodings: IDLE, REQ, BEGIN, DATA, END.
  - CI opcodes: OP_SET_BASE=0, OP_ARM=1, OP_STATUS=2, OP_FRAMES=3.
  - BYTE_ENABLE_ALL=4'hF.
- Sub-module sobel_word_fifo: synchronous FIFO, 32-bit data, depth parameter, push/pop/full/empty/count, async active-low reset.

Test Plan:
- Op0 B=0x1000_0003, op1 B=1, vsync, 32 pixels 0x0001..0x0020 -> one burst: begin addr 0x1000_0000, burstSizeOut=15, first data 0x0002_0001, endTransactionOut after 16 data cycles.
- 3 pixels 0xAAAA, 0xBBBB, 0xCCCC then hsync, then vsync -> flush burst burstSizeOut=1, data 0xBBBB_AAAA, 0x0000_CCCC; op3 returns 1.
- busyIn high for 3 cycles mid-DATA -> dataValidOut held, same addressDataOut word repeated, no pop; burst totals 16 accepted words.
- busErrorIn on 5th data word -> endTransactionOut next cycle, op2 returns bit2=1, next burst address base+64.
- busGrant withheld, 34 words pushed (fifoDepth=32) -> words dropped, op2 bit1=1; a second op2 returns 0 flags.
- reset=0 asserted mid-DATA (asynchronous) -> all outputs 0 within the same cycle; after release op3 returns 0 and requestBus stays 0.
